// File: rtl/midi_pkg.sv
// Shared MIDI definitions: message type codes, status nibbles, real-time bytes,
// decoder state encoding and the status-classification record.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF = 3'd0,
        NOTE_ON  = 3'd1,
        POLY_AT  = 3'd2,
        CC       = 3'd3,
        PROG     = 3'd4,
        CHAN_AT  = 3'd5,
        BEND     = 3'd6
    } msg_type_e;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;

    localparam logic [7:0] RT_CLOCK    = 8'hF8;
    localparam logic [7:0] RT_START    = 8'hFA;
    localparam logic [7:0] RT_CONTINUE = 8'hFB;
    localparam logic [7:0] RT_STOP     = 8'hFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        DISCARD = 2'd3
    } state_e;

    typedef struct packed {
        logic      is_channel;
        logic      is_system;
        logic      is_realtime;
        msg_type_e mtype;
        logic [1:0] dlen;
    } class_t;

    // Status nibbles 0x8..0xE map onto type codes 0..6 via their low three bits.
    function automatic msg_type_e nibble_to_type(input logic [3:0] nib);
        return msg_type_e'(nib[2:0]);
    endfunction

endpackage

// File: rtl/midi_status_classify.sv
// Combinational classifier: byte -> {channel/system/realtime class, type, data length}.
module midi_status_classify
    import midi_pkg::*;
(
    input  logic [7:0] status,
    output class_t     cls
);

    always_comb begin
        cls.is_channel  = 1'b0;
        cls.is_system   = 1'b0;
        cls.is_realtime = 1'b0;
        cls.mtype       = NOTE_OFF;
        cls.dlen        = 2'd0;
        if (status[7]) begin
            if (status[7:4] != 4'hF) begin
                cls.is_channel = 1'b1;
                cls.mtype      = nibble_to_type(status[7:4]);
                cls.dlen       = (status[7:4] == ST_PROG || status[7:4] == ST_CHAN_AT) ? 2'd1 : 2'd2;
            end else if (status[3]) begin
                cls.is_realtime = 1'b1;
            end else begin
                cls.is_system = 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_decoder.sv
// MIDI byte-stream decoder: running status, channel filter, real-time strobes.
// Define MIDI_DECODER_REALTIME_EN to drive the rt_* strobes; otherwise they are tied low.
module midi_decoder
    import midi_pkg::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_re,
    output logic       msg_valid,
    output logic [2:0] msg_type,
    output logic [3:0] msg_channel,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       rt_clock,
    output logic       rt_start,
    output logic       rt_continue,
    output logic       rt_stop
);

    class_t    cls;
    state_e    state_q, state_d;
    msg_type_e run_type_q;
    logic [3:0] run_ch_q;
    logic      run_two_q;
    logic [6:0] d1_q;

    logic      latch_status, latch_d1, emit, accept;
    logic [6:0] e_d1, e_d2;
    msg_type_e e_type;

    assign byte_re = byte_valid;

    midi_status_classify u_classify (
        .status (byte_data),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        latch_status = 1'b0;
        latch_d1     = 1'b0;
        emit         = 1'b0;
        e_d1         = d1_q;
        e_d2         = 7'd0;
        if (byte_valid && !cls.is_realtime) begin
            if (cls.is_channel) begin
                latch_status = 1'b1;
                state_d      = WAIT_D1;
            end else if (cls.is_system) begin
                state_d = DISCARD;
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        latch_d1 = 1'b1;
                        if (run_two_q) begin
                            state_d = WAIT_D2;
                        end else begin
                            emit = 1'b1;
                            e_d1 = byte_data[6:0];
                        end
                    end
                    WAIT_D2: begin
                        emit    = 1'b1;
                        e_d2    = byte_data[6:0];
                        state_d = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Zero-velocity note-on is reported as note-off so the allocator sees one release form.
    assign e_type = (run_type_q == NOTE_ON && e_d2 == 7'd0) ? NOTE_OFF : run_type_q;
    assign accept = OMNI || (run_ch_q == CHANNEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_type_q  <= NOTE_OFF;
            run_ch_q    <= 4'd0;
            run_two_q   <= 1'b0;
            d1_q        <= 7'd0;
            msg_valid   <= 1'b0;
            msg_type    <= 3'd0;
            msg_channel <= 4'd0;
            msg_data1   <= 7'd0;
            msg_data2   <= 7'd0;
        end else begin
            if (latch_status) begin
                run_type_q <= cls.mtype;
                run_ch_q   <= byte_data[3:0];
                run_two_q  <= (cls.dlen == 2'd2);
            end
            if (latch_d1) d1_q <= byte_data[6:0];
            msg_valid <= emit && accept;
            if (emit && accept) begin
                msg_type    <= e_type;
                msg_channel <= run_ch_q;
                msg_data1   <= e_d1;
                msg_data2   <= e_d2;
            end
        end
    end

`ifdef MIDI_DECODER_REALTIME_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rt_clock    <= 1'b0;
            rt_start    <= 1'b0;
            rt_continue <= 1'b0;
            rt_stop     <= 1'b0;
        end else begin
            rt_clock    <= byte_valid && byte_data == RT_CLOCK;
            rt_start    <= byte_valid && byte_data == RT_START;
            rt_continue <= byte_valid && byte_data == RT_CONTINUE;
            rt_stop     <= byte_valid && byte_data == RT_STOP;
        end
    end
`else
    assign rt_clock    = 1'b0;
    assign rt_start    = 1'b0;
    assign rt_continue = 1'b0;
    assign rt_stop     = 1'b0;
`endif

endmodule
